uart_echo_buffer: RTL and testbench
===================================

UART_ECHO_BUFFER -- requirements
Module: uart_echo_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the byte width (legal values are 8 or greater).
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the FIFO entry count (a power of 2, from 2 to 256).
REQ-003 The block SHALL have parameter OVF_WIDTH, default 8, giving the overflow counter width.
REQ-004 The block SHALL run on one clock; reset SHALL be asynchronous and active-low.
REQ-005 i_Clk  input  1  system clock.
REQ-006 i_Rst_L  input  1  asynchronous active-low reset.
REQ-007 i_RX_DV  input  1  one-cycle strobe marking a received byte valid.
REQ-008 i_RX_Byte  input  DATA_WIDTH  received byte, valid while i_RX_DV=1.
REQ-009 i_Mode  input  2  mode: 0=echo, 1=uppercase echo, 2=mute, 3=echo.
REQ-010 i_TX_Done  input  1  one-cycle strobe from the transmitter at end of the stop bit.
REQ-011 o_TX_DV  output  1  one-cycle strobe requesting transmission of o_TX_Byte.
REQ-012 o_TX_Byte  output  DATA_WIDTH  byte to transmit, held stable from o_TX_DV until i_TX_Done.
REQ-013 o_Last_Byte  output  DATA_WIDTH  last received byte, for the 7-segment display.
REQ-014 o_Count  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-015 o_Full / o_Empty  output  1 each  FIFO status flags.
REQ-016 o_Ovf_Count  output  OVF_WIDTH  count of dropped bytes, saturating.

Function
REQ-017 On each i_RX_DV=1, the block SHALL load o_Last_Byte with i_RX_Byte on the next edge, in every mode, full or not.
REQ-018 In modes 0, 1 and 3, i_RX_DV=1 with the FIFO not full SHALL write i_RX_Byte into the FIFO.
REQ-019 In mode 2, the block SHALL perform no FIFO write and SHALL NOT increment o_Ovf_Count.
REQ-020 With i_RX_DV=1, the FIFO full and mode not equal to 2, the block SHALL drop the byte and increment o_Ovf_Count, holding it at all-ones once reached.
REQ-021 A byte SHALL be dropped whenever the FIFO is full at the edge, including when a read occurs in that same cycle.
REQ-022 The FIFO SHALL use wrapping read/write pointers of log2(DEPTH) bits, and o_Count SHALL equal writes minus reads.
REQ-023 o_Full SHALL be asserted exactly when o_Count=DEPTH, and o_Empty exactly when o_Count=0.
REQ-024 A simultaneous write and read with the FIFO not full SHALL leave o_Count unchanged.
REQ-025 The TX state machine SHALL have the states IDLE, LOAD, SEND and WAIT.
REQ-026 IDLE SHALL go to LOAD when o_Empty=0.
REQ-027 LOAD SHALL read the FIFO head into o_TX_Byte, applying the mode transform, and go to SEND.
REQ-028 SEND SHALL drive o_TX_DV=1 for exactly one cycle and go to WAIT.
REQ-029 WAIT SHALL go to IDLE on i_TX_Done=1.
REQ-030 In WAIT, o_TX_DV SHALL be 0 and o_TX_Byte SHALL be held.
REQ-031 The uppercase transform SHALL apply only when the mode sampled in LOAD is 1, subtracting 0x20 from bits [7:0] in the range 0x61..0x7A.
REQ-032 The uppercase transform SHALL leave bits above bit 7 unchanged.
REQ-033 A mode change SHALL never alter a byte already loaded in o_TX_Byte.
REQ-034 The FIFO read SHALL occur on the edge leaving LOAD.
REQ-035 Latency: a write into an empty FIFO at edge N with the machine in IDLE SHALL give o_TX_DV=1 during the cycle after edge N+2.
REQ-036 An i_TX_Done received outside WAIT SHALL be ignored.
REQ-037 Switching to mode 2 SHALL still drain the bytes already queued.

Reset
REQ-038 While i_Rst_L=0, all outputs and state SHALL be forced immediately, regardless of the clock.
REQ-039 The reset values SHALL be: o_TX_DV=0, o_TX_Byte=0, o_Last_Byte=0, o_Count=0, o_Empty=1, o_Full=0, o_Ovf_Count=0, state IDLE, and both pointers 0.
REQ-040 FIFO storage contents need not be cleared by reset.
REQ-041 A reset asserted in WAIT SHALL abandon the pending byte, with no o_TX_DV after release until a new write.
REQ-042 The block SHALL accept the first i_RX_DV on the first clock edge after reset release.

Verification
REQ-043 Echo: mode 0, send 0x41 -> o_Last_Byte=0x41, exactly one o_TX_DV pulse with o_TX_Byte=0x41, and o_Count back to 0 after LOAD.
REQ-044 Uppercase: mode 1, send 0x61, 0x7A, 0x7B, 0x5A -> o_TX_Byte sequence 0x41, 0x5A, 0x7B, 0x5A.
REQ-045 Overflow: DEPTH=16, i_TX_Done never pulsed, send 20 bytes -> o_Full=1, o_Count=16, o_Ovf_Count=3 (one byte in TX), then 300 more bytes -> o_Ovf_Count=255.
REQ-046 Mute: mode 2, send 0x33 -> o_Last_Byte=0x33, no o_TX_DV, o_Count=0, o_Ovf_Count unchanged.
REQ-047 Simultaneous write and read: with the FIFO holding 15 entries, a write and a read on the same edge -> o_Count stays 15 and order is preserved; with 16 entries, the byte is dropped and o_Ovf_Count increments.
REQ-048 Reset: assert i_Rst_L=0 mid-WAIT with 5 bytes queued -> all outputs at reset values asynchronously, and no o_TX_DV after release.

Source files
------------

// File: rtl/uart_echo_buffer.sv
// UART echo path: received bytes are queued in a small FIFO and replayed to the
// transmitter, optionally upper-cased, with a saturating count of dropped bytes.
module uart_echo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int OVF_WIDTH  = 8
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  input  logic                      i_RX_DV,
  input  logic [DATA_WIDTH-1:0]     i_RX_Byte,
  input  logic [1:0]                i_Mode,
  input  logic                      i_TX_Done,
  output logic                      o_TX_DV,
  output logic [DATA_WIDTH-1:0]     o_TX_Byte,
  output logic [DATA_WIDTH-1:0]     o_Last_Byte,
  output logic [$clog2(DEPTH):0]    o_Count,
  output logic                      o_Full,
  output logic                      o_Empty,
  output logic [OVF_WIDTH-1:0]      o_Ovf_Count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  accept, wr_en, rd_en, drop;
  logic [DATA_WIDTH-1:0] head, head_x;

  // Fullness is judged at the edge: a read in the same cycle does not make room.
  assign accept  = i_RX_DV & (i_Mode != 2'd2);
  assign wr_en   = accept & ~o_Full;
  assign drop    = accept & o_Full;
  assign rd_en   = (state == LOAD);
  assign o_Full  = (count == FULL_CNT);
  assign o_Empty = (count == '0);
  assign o_Count = count;
  assign o_TX_DV = (state == SEND);
  assign head    = mem[rd_ptr];

  always_comb begin
    head_x = head;
    if (i_Mode == 2'd1 && head[7:0] >= 8'h61 && head[7:0] <= 8'h7A)
      head_x[7:0] = head[7:0] - 8'h20;
  end

  always_ff @(posedge i_Clk)
    if (wr_en) mem[wr_ptr] <= i_RX_Byte;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_Last_Byte <= '0;
      o_Ovf_Count <= '0;
    end else begin
      if (i_RX_DV) o_Last_Byte <= i_RX_Byte;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && o_Ovf_Count != '1) o_Ovf_Count <= o_Ovf_Count + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state     <= IDLE;
      o_TX_Byte <= '0;
    end else begin
      state <= state_nxt;
      // Mode is sampled only here, so a later mode change cannot touch a loaded byte.
      if (state == LOAD) o_TX_Byte <= head_x;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!o_Empty) state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    state_nxt = WAIT;
      WAIT:    if (i_TX_Done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench for uart_echo_buffer: echo, uppercase, mute, overflow,
// same-edge write/read and mid-transfer async reset.
module tb_uart_echo_buffer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic [1:0] mode;
  logic       done_man, done_auto, auto_done;
  logic       tx_done;
  logic       tx_dv;
  logic [7:0] tx_byte, last_byte;
  logic [4:0] count;
  logic       full, empty;
  logic [7:0] ovf;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] txq[$];
  logic [7:0] exp_q[18];
  int n0;

  assign tx_done = done_man | done_auto;

  uart_echo_buffer #(.DATA_WIDTH(8), .DEPTH(16), .OVF_WIDTH(8)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
    .i_Mode(mode), .i_TX_Done(tx_done), .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte),
    .o_Last_Byte(last_byte), .o_Count(count), .o_Full(full), .o_Empty(empty),
    .o_Ovf_Count(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_dv = 1'b1; rx_byte = b;
    tick;
    rx_dv = 1'b0;
  endtask

  // Release WAIT, then land a write on the edge that leaves LOAD.
  task automatic rd_wr(input logic [7:0] b);
    done_man = 1'b1; tick;
    done_man = 1'b0; tick;
    send(b);
  endtask

  initial forever begin
    @(negedge clk);
    if (tx_dv === 1'b1) txq.push_back(tx_byte);
  end

  initial begin
    done_auto = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (auto_done && tx_dv) begin
        repeat (2) @(posedge clk);
        #2 done_auto = 1'b1;
        @(posedge clk);
        #2 done_auto = 1'b0;
      end
    end
  end

  initial begin
    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = '0; mode = 2'd0;
    done_man = 1'b0; auto_done = 1'b1;
    #1;
    chk("rst_dv", tx_dv, 0);     chk("rst_txb", tx_byte, 0);
    chk("rst_last", last_byte, 0); chk("rst_cnt", count, 0);
    chk("rst_empty", empty, 1);  chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Echo, first edge after release, latency
    send(8'h41);
    chk("echo_last", last_byte, 8'h41); chk("echo_cnt1", count, 1);
    tick; chk("echo_dv_n1", tx_dv, 0);
    tick; chk("echo_dv_n2", tx_dv, 1); chk("echo_txb", tx_byte, 8'h41);
    chk("echo_cnt0", count, 0);
    tick; chk("echo_dv_wait", tx_dv, 0);
    repeat (10) tick;
    chk("echo_npulse", txq.size(), 1); chk("echo_q0", txq[0], 8'h41);

    // Uppercase
    mode = 2'd1;
    send(8'h61); send(8'h7A); send(8'h7B); send(8'h5A);
    repeat (40) tick;
    chk("up_n", txq.size(), 5);
    chk("up_61", txq[1], 8'h41); chk("up_7a", txq[2], 8'h5A);
    chk("up_7b", txq[3], 8'h7B); chk("up_5a", txq[4], 8'h5A);

    // Mode change after LOAD leaves the loaded byte alone
    send(8'h62); tick; tick;
    chk("mc_txb", tx_byte, 8'h42);
    mode = 2'd0; tick;
    chk("mc_hold", tx_byte, 8'h42);
    repeat (10) tick;

    // Mute
    mode = 2'd2;
    send(8'h33);
    repeat (10) tick;
    chk("mute_last", last_byte, 8'h33); chk("mute_n", txq.size(), 6);
    chk("mute_cnt", count, 0); chk("mute_ovf", ovf, 0);

    // Overflow and saturation
    auto_done = 1'b0; mode = 2'd0;
    for (int i = 0; i < 20; i++) send(8'h10 + 8'(i));
    chk("ovf_full", full, 1); chk("ovf_cnt", count, 16);
    chk("ovf_3", ovf, 3); chk("ovf_txb", tx_byte, 8'h10);
    chk("ovf_n", txq.size(), 7);
    for (int i = 0; i < 300; i++) send(8'(i));
    chk("ovf_sat", ovf, 8'hFF); chk("ovf_cnt2", count, 16);

    #2 rst_n = 1'b0; #1;
    chk("rst2_ovf", ovf, 0);
    @(negedge clk) rst_n = 1'b1;
    txq.delete();

    // Same-edge write and read
    for (int i = 0; i < 17; i++) send(8'h20 + 8'(i));
    chk("sim_cnt16", count, 16); chk("sim_ovf0", ovf, 0);
    rd_wr(8'hEE);
    chk("sim_drop_cnt", count, 15); chk("sim_drop_ovf", ovf, 1);
    chk("sim_drop_txb", tx_byte, 8'h21);
    tick;
    rd_wr(8'hEF);
    chk("sim_keep_cnt", count, 15); chk("sim_keep_ovf", ovf, 1);
    chk("sim_keep_txb", tx_byte, 8'h22);
    tick;
    done_man = 1'b1; tick; done_man = 1'b0;
    auto_done = 1'b1;
    repeat (150) tick;
    for (int k = 0; k < 17; k++) exp_q[k] = 8'h20 + 8'(k);
    exp_q[17] = 8'hEF;
    chk("ord_n", txq.size(), 18);
    for (int k = 0; k < 18; k++)
      if (k < txq.size()) chk($sformatf("ord_%0d", k), txq[k], exp_q[k]);
    chk("ord_empty", empty, 1);

    // Async reset mid-WAIT with 5 queued
    auto_done = 1'b0;
    for (int i = 0; i < 6; i++) send(8'h50 + 8'(i));
    repeat (3) tick;
    chk("rw_cnt5", count, 5);
    #2 rst_n = 1'b0; #1;
    chk("rw_dv", tx_dv, 0);     chk("rw_txb", tx_byte, 0);
    chk("rw_last", last_byte, 0); chk("rw_cnt", count, 0);
    chk("rw_empty", empty, 1);  chk("rw_full", full, 0);
    chk("rw_ovf", ovf, 0);
    n0 = txq.size();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    auto_done = 1'b1;
    repeat (20) tick;
    chk("rw_nodv", txq.size(), n0);
    chk("rw_empty2", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
